// File: rtl/violation_reset_ctrl.sv
// Merges RoT monitor violation flags into one stretched MCU system reset.
// Records which sources fired and counts episodes until the core restarts.
module violation_reset_ctrl #(
  parameter int unsigned NUM_SRC       = 4,
  parameter int unsigned HOLD_CYCLES   = 8,
  parameter int unsigned CNT_W         = 8,
  parameter logic [15:0] RESET_HANDLER = 16'hfffe
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        pc,
  input  logic [NUM_SRC-1:0] viol_in,
  output logic               system_reset,
  output logic [NUM_SRC-1:0] viol_cause,
  output logic [CNT_W-1:0]   viol_count,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t             state;
  logic [7:0]         hold;
  logic               any_viol;
  logic               pc_home;
  logic [CNT_W-1:0]   cnt_inc;

  assign any_viol = |viol_in;
  assign pc_home  = (pc == RESET_HANDLER);

  // Saturate at all-ones so a storm of episodes never wraps to a small value.
  assign cnt_inc = (&viol_count) ? viol_count
                                 : viol_count + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hold         <= 8'd0;
      system_reset <= 1'b0;
      viol_cause   <= '0;
      viol_count   <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_viol) begin
            state        <= ASSERT;
            hold         <= HOLD_LOAD;
            system_reset <= 1'b1;
            busy         <= 1'b1;
            viol_cause   <= viol_in;
            viol_count   <= cnt_inc;
          end
        end
        ASSERT: begin
          viol_cause <= viol_cause | viol_in;
          if (hold == 8'd0) begin
            state        <= RELEASE;
            system_reset <= 1'b0;
          end else begin
            hold <= hold - 8'd1;
          end
        end
        RELEASE: begin
          // A fresh violation wins over the core reaching its handler.
          if (any_viol) begin
            state        <= ASSERT;
            hold         <= HOLD_LOAD;
            system_reset <= 1'b1;
            viol_cause   <= viol_cause | viol_in;
            viol_count   <= cnt_inc;
          end else if (pc_home) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          system_reset <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_violation_reset_ctrl.sv
// Scoreboard bench for violation_reset_ctrl: a behavioural model queues
// expected outputs per cycle; a second instance uses a 2-bit episode counter.
module tb_violation_reset_ctrl;

  localparam int HOLD = 8;
  localparam logic [15:0] RH = 16'hfffe;

  typedef struct packed {
    logic       sr;
    logic [3:0] cause;
    logic [7:0] cnt;
    logic       busy;
    logic [1:0] cnt2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = 16'h0;
  logic [3:0]  viol_in = 4'h0;

  logic       system_reset, system_reset2;
  logic [3:0] viol_cause, viol_cause2;
  logic [7:0] viol_count;
  logic [1:0] viol_count2;
  logic       busy, busy2;

  violation_reset_ctrl dut (
    .clk(clk), .rst(rst), .pc(pc), .viol_in(viol_in),
    .system_reset(system_reset), .viol_cause(viol_cause),
    .viol_count(viol_count), .busy(busy)
  );

  violation_reset_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .pc(pc), .viol_in(viol_in),
    .system_reset(system_reset2), .viol_cause(viol_cause2),
    .viol_count(viol_count2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];

  // Reference model state
  int         m_st = 0;
  int         m_left = 0;
  logic [3:0] m_cause = 4'h0;
  int         m_cnt = 0;
  int         run = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_left = 0; m_cause = 4'h0; m_cnt = 0; run = 0;
    sb.delete();
  endtask

  task automatic model_step(input logic [3:0] v, input logic [15:0] p);
    exp_t e;
    if (m_st == 0) begin
      if (v != 4'h0) begin
        m_st = 1; m_left = HOLD; m_cause = v; m_cnt++;
      end
    end else if (m_st == 1) begin
      m_cause |= v;
      m_left--;
      if (m_left == 0) m_st = 2;
    end else begin
      if (v != 4'h0) begin
        m_st = 1; m_left = HOLD; m_cause |= v; m_cnt++;
      end else if (p == RH) begin
        m_st = 0;
      end
    end
    e.sr    = (m_st == 1);
    e.busy  = (m_st != 0);
    e.cause = m_cause;
    e.cnt   = (m_cnt > 255) ? 8'hff : 8'(m_cnt);
    e.cnt2  = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
    sb.push_back(e);
  endtask

  task automatic cyc(input logic [3:0] v, input logic [15:0] p);
    exp_t e;
    viol_in = v;
    pc = p;
    model_step(v, p);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("system_reset", 32'(system_reset), 32'(e.sr));
      chk("viol_cause",   32'(viol_cause),   32'(e.cause));
      chk("viol_count",   32'(viol_count),   32'(e.cnt));
      chk("busy",         32'(busy),         32'(e.busy));
      chk("count_sat2",   32'(viol_count2),  32'(e.cnt2));
      chk("sr_w2",        32'(system_reset2), 32'(e.sr));
    end
    if (system_reset) begin
      run++;
    end else if (run != 0) begin
      chk("hold_len", 32'(run), 32'(HOLD));
      run = 0;
    end
  endtask

  task automatic idle_n(input int n, input logic [15:0] p);
    for (int i = 0; i < n; i++) cyc(4'h0, p);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sr",    32'(system_reset), 32'd0);
    chk("rst_cause", 32'(viol_cause),   32'd0);
    chk("rst_count", 32'(viol_count),   32'd0);
    chk("rst_busy",  32'(busy),         32'd0);
    rst = 1'b0;
    idle_n(2, 16'h0);

    // Basic episode, then core returns to handler
    cyc(4'b0001, 16'h0);
    idle_n(10, 16'h0100);
    cyc(4'h0, RH);
    chk("idle_busy", 32'(busy), 32'd0);
    idle_n(2, 16'h0);

    // Multi-source accumulation inside one hold
    cyc(4'b0001, 16'h0);
    idle_n(2, 16'h0);
    cyc(4'b0100, 16'h0);
    chk("accum_cause", 32'(viol_cause), 32'h5);
    idle_n(6, 16'h0);

    // Re-violation in RELEASE keeps and ORs the cause
    cyc(4'b0010, 16'h0);
    chk("rev_count", 32'(viol_count), 32'd3);
    cyc(4'b0001, RH);
    idle_n(8, 16'h0);
    // Violation and handler PC together: violation wins
    cyc(4'b0001, RH);
    chk("prio_sr", 32'(system_reset), 32'd1);
    idle_n(8, 16'h0);
    cyc(4'h0, RH);

    // New episode from IDLE overwrites the cause
    cyc(4'b1000, 16'h0);
    chk("ovw_cause", 32'(viol_cause), 32'h8);
    idle_n(9, RH);

    // Randomised episodes and PC activity
    for (int i = 0; i < 400; i++) begin
      logic [3:0] v;
      logic [15:0] p;
      v = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
      p = ($urandom_range(0, 5) == 0) ? RH : 16'($urandom);
      cyc(v, p);
    end
    idle_n(HOLD + 1, 16'h0);
    cyc(4'h0, RH);

    // Async reset in the 4th cycle of a hold
    cyc(4'b0001, 16'h0);
    idle_n(3, 16'h0);
    chk("pre_rst_sr", 32'(system_reset), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_sr",    32'(system_reset), 32'd0);
    chk("arst_cause", 32'(viol_cause),   32'd0);
    chk("arst_count", 32'(viol_count),   32'd0);
    chk("arst_busy",  32'(busy),         32'd0);
    chk("arst_cnt2",  32'(viol_count2),  32'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle_n(3, 16'h0);
    cyc(4'b0010, 16'h0);
    chk("post_rst_count", 32'(viol_count), 32'd1);
    idle_n(9, 16'h0);
    cyc(4'h0, RH);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
